// File: rtl/cluster_seq_pkg.sv
// Shared types and default widths for the cluster step sequencer.
package cluster_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } seq_state_t;

  localparam int CL_IN_W  = 1894;
  localparam int CL_OUT_W = 128;
  localparam int STEP_W   = 16;

  // Width of a counter that must hold SETTLE-1; never narrower than one bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/cluster_settle_timer.sv
// Loadable down-counter timing the settle window; zero flags the capture cycle.
module cluster_settle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/cluster_step_sequencer.sv
// Drives the cluster input vector, holds it for SETTLE cycles per step, feeds
// outputs back for multi-step runs and returns the last capture over valid/ready.
module cluster_step_sequencer #(
  parameter int IN_W   = cluster_seq_pkg::CL_IN_W,
  parameter int OUT_W  = cluster_seq_pkg::CL_OUT_W,
  parameter int FB_LSB = 0,
  parameter int SETTLE = 4,
  parameter int STEP_W = cluster_seq_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IN_W-1:0]   req_vec,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              abort,
  output logic [IN_W-1:0]   cl_in,
  input  logic [OUT_W-1:0]  cl_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_vec,
  output logic [STEP_W-1:0] rsp_steps,
  output logic              busy
);

  import cluster_seq_pkg::*;

  localparam int CNT_W = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  seq_state_t        r_state;
  logic [IN_W-1:0]   r_cl_in;
  logic [STEP_W-1:0] r_steps_left;
  logic [STEP_W-1:0] r_done_cnt;
  logic [OUT_W-1:0]  r_rsp_vec;
  logic [STEP_W-1:0] r_rsp_steps;
  logic              r_rsp_valid;

  logic w_zero;
  logic w_accept;
  logic w_feedback;
  logic w_timer_load;
  logic w_timer_dec;

  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_feedback   = (r_state == ST_SETTLE) && !abort && w_zero && (r_steps_left != STEP_ONE);
  assign w_timer_load = w_accept || w_feedback;
  assign w_timer_dec  = (r_state == ST_SETTLE) && !w_zero;

  cluster_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_timer_load),
    .load_val (SETTLE_RELOAD),
    .dec      (w_timer_dec),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cl_in      <= '0;
      r_steps_left <= '0;
      r_done_cnt   <= '0;
      r_rsp_vec    <= '0;
      r_rsp_steps  <= '0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cl_in      <= req_vec;
            r_steps_left <= (req_steps == '0) ? STEP_ONE : req_steps;
            r_done_cnt   <= '0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Abort outranks a capture landing on the same edge.
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_zero) begin
            if (r_steps_left != STEP_ONE) begin
              r_cl_in[FB_LSB +: OUT_W] <= cl_out;
              r_steps_left             <= r_steps_left - STEP_ONE;
              if (r_done_cnt != '1) begin
                r_done_cnt <= r_done_cnt + STEP_ONE;
              end
            end else begin
              r_rsp_vec   <= cl_out;
              r_rsp_steps <= r_done_cnt + STEP_ONE;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cl_in     = r_cl_in;
  assign rsp_vec   = r_rsp_vec;
  assign rsp_steps = r_rsp_steps;
  assign rsp_valid = r_rsp_valid;
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cluster_step_sequencer.sv
// Directed bench for cluster_step_sequencer with an inverting cluster model and
// a response scoreboard.
module tb_cluster_step_sequencer;

  localparam int IN_W   = 1894;
  localparam int OUT_W  = 128;
  localparam int FB_LSB = 0;
  localparam int SETTLE = 4;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [IN_W-1:0]   req_vec;
  logic [STEP_W-1:0] req_steps;
  logic              abort;
  logic [IN_W-1:0]   cl_in;
  logic [OUT_W-1:0]  cl_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OUT_W-1:0]  rsp_vec;
  logic [STEP_W-1:0] rsp_steps;
  logic              busy;

  typedef struct {
    logic [OUT_W-1:0]  vec;
    logic [STEP_W-1:0] steps;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Cluster model: each output bit is the inverse of the matching feedback input bit.
  assign cl_out = ~cl_in[FB_LSB +: OUT_W];

  cluster_step_sequencer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .FB_LSB (FB_LSB),
    .SETTLE (SETTLE),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .req_steps (req_steps),
    .abort     (abort),
    .cl_in     (cl_in),
    .cl_out    (cl_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_vec   (rsp_vec),
    .rsp_steps (rsp_steps),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed[127:0]=%h expected[127:0]=%h differing_bits=%0d",
             tag, obs[127:0], exp[127:0], $countones(obs ^ exp));
    end
  endtask

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W; i++) r[i] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  // Drive one request and push its expected response; returns after acceptance edge E0.
  task automatic start_req(input logic [IN_W-1:0] vec, input logic [STEP_W-1:0] steps,
                           input logic with_abort);
    exp_t e;
    int   eff;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_req", req_ready, 1);
    eff       = (steps == 0) ? 1 : int'(steps);
    e.vec     = eff[0] ? ~vec[OUT_W-1:0] : vec[OUT_W-1:0];
    e.steps   = STEP_W'(eff);
    sb_q.push_back(e);
    req_vec   = vec;
    req_steps = steps;
    req_valid = 1'b1;
    abort     = with_abort;
    @(posedge clk); #1;
    req_valid = 1'b0;
    abort     = 1'b0;
    chk("accept_busy", busy, 1);
    chk_vec("accept_cl_in", cl_in, vec);
  endtask

  // Count edges after E0 until rsp_valid, then score the response.
  task automatic wait_rsp(input int exp_edges, input logic [IN_W-1:0] vec);
    int   n = 0;
    logic upper_ok = 1'b1;
    exp_t e;
    while (!rsp_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (cl_in[IN_W-1:OUT_W] !== vec[IN_W-1:OUT_W]) upper_ok = 1'b0;
    end
    chk("rsp_latency", n, exp_edges);
    chk("upper_bits_frozen", upper_ok, 1);
    chk("sb_size", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rsp_vec", rsp_vec, e.vec);
      chk("rsp_steps", rsp_steps, e.steps);
    end
    $display("[TB] rsp after %0d edges: steps=%0d vec=%h", n, rsp_steps, rsp_vec);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_rsp_valid_clear", rsp_valid, 0);
    chk("hs_req_ready", req_ready, 1);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    logic [IN_W-1:0]  v;
    logic [IN_W-1:0]  v2;
    logic [IN_W-1:0]  held_cl_in;
    logic [OUT_W-1:0] held_rsp;
    logic             bp_vec_ok;
    logic             bp_ready_ok;
    logic             bp_valid_ok;
    logic             bp_clin_ok;

    rst_n = 1'b0; req_valid = 1'b0; req_vec = '0; req_steps = '0;
    abort = 1'b0; rsp_ready = 1'b0;
    #1;
    chk_vec("reset_cl_in", cl_in, '0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_vec", rsp_vec, 0);
    chk("reset_rsp_steps", rsp_steps, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", req_ready, 1);

    // Single step
    v = rand_vec();
    start_req(v, 1, 1'b0);
    wait_rsp(SETTLE, v);
    handshake();

    // Feedback over three steps
    v = rand_vec();
    start_req(v, 3, 1'b0);
    wait_rsp(3 * SETTLE, v);
    handshake();

    // Two steps: even inversion count returns the original low bits
    v = rand_vec();
    start_req(v, 2, 1'b0);
    wait_rsp(2 * SETTLE, v);
    handshake();

    // Zero steps behaves as one; abort alongside an IDLE request is ignored
    v = rand_vec();
    start_req(v, 0, 1'b1);
    wait_rsp(SETTLE, v);
    handshake();

    // Backpressure with a competing request and abort held in RESP
    v  = rand_vec();
    v2 = rand_vec();
    start_req(v, 2, 1'b0);
    wait_rsp(2 * SETTLE, v);
    held_rsp   = rsp_vec;
    held_cl_in = cl_in;
    bp_vec_ok = 1'b1; bp_ready_ok = 1'b1; bp_valid_ok = 1'b1; bp_clin_ok = 1'b1;
    req_vec = v2; req_steps = 1; req_valid = 1'b1; abort = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_vec !== held_rsp) bp_vec_ok = 1'b0;
      if (req_ready !== 1'b0) bp_ready_ok = 1'b0;
      if (rsp_valid !== 1'b1) bp_valid_ok = 1'b0;
      if (cl_in !== held_cl_in) bp_clin_ok = 1'b0;
    end
    req_valid = 1'b0; abort = 1'b0;
    chk("bp_rsp_vec_stable", bp_vec_ok, 1);
    chk("bp_req_ready_low", bp_ready_ok, 1);
    chk("bp_rsp_valid_held", bp_valid_ok, 1);
    chk("bp_no_accept", bp_clin_ok, 1);
    handshake();

    // Abort during SETTLE: driven after E2, sampled at E3
    v = rand_vec();
    start_req(v, 2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk_vec("abort_cl_in_kept", cl_in, v);
    void'(sb_q.pop_back());
    $display("[TB] aborted request");
    v = rand_vec();
    start_req(v, 1, 1'b0);
    wait_rsp(SETTLE, v);
    handshake();

    // Asynchronous reset mid-run
    v = rand_vec();
    start_req(v, 3, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_vec("midrst_cl_in", cl_in, '0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    void'(sb_q.pop_back());
    $display("[TB] reset mid-run");
    @(posedge clk); #1 rst_n = 1'b1;
    v = rand_vec();
    start_req(v, 3, 1'b0);
    wait_rsp(3 * SETTLE, v);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
